// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit scan controller: digit count, FSM states
// and the per-digit common-select patterns.
package seg_scan_ctrl_pkg;

    localparam int N_DIG = 4;

    typedef enum logic {
        S_SHOW,
        S_GAP
    } state_t;

    // Element i is the select pattern for digit i; digit 0 (LSD) sits on com[3].
    localparam logic [N_DIG-1:0][3:0] COM_ONEHOT = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

endpackage

// File: rtl/seg_7.sv
// Hex nibble to 7-segment decoder, active-high segments, bit0 = segment a.
module seg_7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, on the last count.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed display scanner with dwell/blank timing, frame-boundary
// double-buffered loads, digit masking and leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_req,
    input  logic [15:0] load_data,
    output logic        load_ack,
    input  logic        lz_en,
    input  logic [3:0]  dig_en,
    output logic [3:0]  com,
    output logic [6:0]  data_out,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam int            CNT_MAX    = (DWELL > GAP) ? DWELL : GAP;
    localparam int            DW         = $clog2(CNT_MAX + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pend_buf_q, pend_buf_d;
    logic          pending_q, pending_d;
    logic          load_ack_q, load_ack_d;
    logic          frame_start_q, frame_start_d;
    logic          tick;
    logic          frame_boundary;
    logic          suppressed;
    logic [3:0]    nibble;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        idx_d   = idx_q;
        if (tick) begin
            unique case (state_q)
                S_SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (GAP > 0) state_d = S_GAP;
                        else         idx_d   = idx_q + 2'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (dwell_q == GAP_LAST) begin
                        dwell_d = '0;
                        state_d = S_SHOW;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            endcase
        end
        // The index only ever increments, so 3 -> 0 is exactly the frame wrap.
        frame_boundary = (idx_q == 2'd3) && (idx_d == 2'd0);
    end

    // Ack blocks capture for its own cycle so a still-held request is not re-taken.
    always_comb begin
        active_d      = active_q;
        pend_buf_d    = pend_buf_q;
        pending_d     = pending_q;
        frame_start_d = frame_boundary;
        load_ack_d    = frame_boundary && pending_q;
        if (load_ack_d) begin
            active_d  = pend_buf_q;
            pending_d = 1'b0;
        end else if (load_req && !pending_q && !load_ack_q) begin
            pend_buf_d = load_data;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_SHOW;
            dwell_q       <= '0;
            idx_q         <= 2'd0;
            active_q      <= 16'h0000;
            pend_buf_q    <= 16'h0000;
            pending_q     <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pend_buf_q    <= pend_buf_d;
            pending_q     <= pending_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        nibble     = active_q[{idx_q, 2'b00} +: 4];
        suppressed = lz_en && (idx_q != 2'd0) && ((active_q >> {idx_q, 2'b00}) == 16'h0000);
        com        = (state_q == S_SHOW && dig_en[idx_q] && !suppressed) ? COM_ONEHOT[idx_q] : 4'b0000;
    end

    seg_7 u_seg_7 (
        .nibble (nibble),
        .seg    (data_out)
    );

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign digit_idx   = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised self-checking bench for seg_scan_ctrl against a timeline model,
// plus a GAP=0 instance for the no-blank frame timing.
module tb_seg_scan_ctrl;

    localparam int DIV   = 2;
    localparam int DWELL = 2;
    localparam int GAP   = 1;
    localparam int F1    = 4 * (DWELL + GAP) * DIV;
    localparam int F2    = 4 * DWELL * DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  dig_en = 4'hF;
    logic        load_ack, frame_start;
    logic [3:0]  com;
    logic [6:0]  data_out;
    logic [1:0]  digit_idx;

    logic        load_req2 = 1'b0;
    logic [15:0] load_data2 = 16'h0;
    logic        lz_en2 = 1'b0;
    logic [3:0]  dig_en2 = 4'hF;
    logic        load_ack2, frame_start2;
    logic [3:0]  com2;
    logic [6:0]  data_out2;
    logic [1:0]  digit_idx2;

    int checks = 0;
    int failures = 0;

    int          t = 0;
    bit          model_valid = 1'b0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_buf = 16'h0;
    bit          m_pending = 1'b0;
    bit          m_ack = 1'b0;

    seg_scan_ctrl #(.DIV(DIV), .DWELL(DWELL), .GAP(GAP)) dut (
        .clock(clock), .reset(reset), .load_req(load_req), .load_data(load_data),
        .load_ack(load_ack), .lz_en(lz_en), .dig_en(dig_en), .com(com),
        .data_out(data_out), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    seg_scan_ctrl #(.DIV(DIV), .DWELL(DWELL), .GAP(0)) dut_nogap (
        .clock(clock), .reset(reset), .load_req(load_req2), .load_data(load_data2),
        .load_ack(load_ack2), .lz_en(lz_en2), .dig_en(dig_en2), .com(com2),
        .data_out(data_out2), .digit_idx(digit_idx2), .frame_start(frame_start2)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Digit slot of cycle tt: each slot is (DWELL+gap)*DIV cycles, shown for the first DWELL*DIV.
    function automatic int slotOf(input int tt, input int gp);
        int len = (DWELL + gp) * DIV;
        return (tt % (4 * len)) / len;
    endfunction

    function automatic logic [3:0] expCom(input int tt, input int gp, input logic [15:0] act,
                                          input logic [3:0] en, input logic lz);
        int len = (DWELL + gp) * DIV;
        int s   = slotOf(tt, gp);
        bit show = ((tt % (4 * len)) % len) < DWELL * DIV;
        bit sup  = lz && (s > 0) && ((act >> (4 * s)) == 16'h0);
        return (show && en[s] && !sup) ? (4'b1000 >> s) : 4'b0000;
    endfunction

    function automatic logic [6:0] expSeg(input int tt, input int gp, input logic [15:0] act);
        int s = slotOf(tt, gp);
        return segOf(act[4*s +: 4]);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s t=%0d actual=%h expected=%h", name, t, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [15:0] data);
        #1;
        load_req  = req;
        load_data = data;
    endtask

    task automatic waitT(input int target);
        for (int k = 0; k < 200 && t != target; k++) @(negedge clock);
        if (t != target) begin
            failures++;
            checks++;
            $display("[TB] FAIL wait_t actual=%0d expected=%0d", t, target);
        end
    endtask

    // Load model: captures when idle, applies at each frame wrap, all in timeline terms.
    always @(posedge clock) begin
        if (reset) begin
            t = 0; m_active = 16'h0; m_buf = 16'h0; m_pending = 1'b0; m_ack = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            bit prev_ack = m_ack;
            m_ack = (((t + 1) % F1) == 0) && m_pending;
            if (m_ack) begin
                m_active  = m_buf;
                m_pending = 1'b0;
            end else if (load_req && !m_pending && !prev_ack) begin
                m_buf     = load_data;
                m_pending = 1'b1;
            end
            t++;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("com", com, expCom(t, GAP, m_active, dig_en, lz_en));
            checkOutput("data_out", data_out, expSeg(t, GAP, m_active));
            checkOutput("digit_idx", digit_idx, slotOf(t, GAP));
            checkOutput("frame_start", frame_start, (t > 0) && (t % F1 == 0));
            checkOutput("load_ack", load_ack, m_ack);
            checkOutput("nogap_com", com2, expCom(t, 0, 16'h0, 4'hF, 1'b0));
            checkOutput("nogap_idx", digit_idx2, slotOf(t, 0));
            checkOutput("nogap_frame_start", frame_start2, (t > 0) && (t % F2 == 0));
            checkOutput("nogap_load_ack", load_ack2, 1'b0);
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        checkOutput("rst_com", com, 4'b1000);
        checkOutput("rst_data", data_out, 7'h3F);
        checkOutput("rst_frame_start", frame_start, 1'b0);
        checkOutput("rst_ack", load_ack, 1'b0);
        #1 reset = 1'b0;

        waitT(4);   checkOutput("lit_gap_com", com, 4'b0000);
                    checkOutput("lit_nogap_slot1", com2, 4'b0100);
        waitT(16);  checkOutput("lit_nogap_frame", frame_start2, 1'b1);
        waitT(24);  checkOutput("lit_frame24", frame_start, 1'b1);
        waitT(30);  applyStimulus(1'b1, 16'h0042);
        waitT(47);  checkOutput("lit_pre_ack", load_ack, 1'b0);
                    checkOutput("lit_pre_data", data_out, 7'h3F);
        waitT(48);  checkOutput("lit_ack1", load_ack, 1'b1);
                    checkOutput("lit_ack1_frame", frame_start, 1'b1);
                    checkOutput("lit_digit0_2", data_out, 7'h5B);
                    applyStimulus(1'b1, 16'h1234);
        waitT(50);  applyStimulus(1'b0, 16'h1234);
                    lz_en = 1'b1;
        waitT(54);  checkOutput("lit_digit1_4", data_out, 7'h66);
                    checkOutput("lit_digit1_com", com, 4'b0100);
        waitT(60);  checkOutput("lit_lz_digit2", com, 4'b0000);
        waitT(72);  checkOutput("lit_ack2", load_ack, 1'b1);
                    checkOutput("lit_1234_d0", data_out, 7'h66);
        waitT(78);  checkOutput("lit_1234_d1", data_out, 7'h4F);
        waitT(80);  applyStimulus(1'b1, 16'h0400);
        waitT(96);  checkOutput("lit_ack3", load_ack, 1'b1);
                    applyStimulus(1'b0, 16'h0400);
        waitT(102); checkOutput("lit_0400_d1", com, 4'b0100);
        waitT(108); checkOutput("lit_0400_d2", com, 4'b0010);
        waitT(110); applyStimulus(1'b1, 16'h0000);
        waitT(114); checkOutput("lit_0400_d3", com, 4'b0000);
        waitT(120); checkOutput("lit_ack4", load_ack, 1'b1);
                    checkOutput("lit_zero_d0", com, 4'b1000);
                    applyStimulus(1'b0, 16'h0000);
        waitT(126); checkOutput("lit_zero_d1", com, 4'b0000);
        waitT(140); #1 dig_en = 4'b1110; lz_en = 1'b0;
        waitT(144); checkOutput("lit_mask_d0", com, 4'b0000);
                    checkOutput("lit_mask_frame", frame_start, 1'b1);
        waitT(150); checkOutput("lit_mask_d1", com, 4'b0100);
        waitT(168); checkOutput("lit_mask_frame2", frame_start, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 19) == 0) dig_en = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lz_en = 1'($urandom_range(0, 1));
            if (load_req && load_ack) begin
                load_req = 1'b0;
            end else if (load_req) begin
                if ($urandom_range(0, 3) == 0) load_data = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                load_req  = 1'b1;
                load_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
        end

        #1 load_req = 1'b0; dig_en = 4'hF; lz_en = 1'b0;
        for (int k = 0; k < 100 && !((t % F1) >= 2 && (t % F1) <= 10); k++) @(negedge clock);
        applyStimulus(1'b1, 16'hABCD);
        @(negedge clock);
        #1 reset = 1'b1; load_req = 1'b0;
        @(negedge clock);
        checkOutput("mid_rst_com", com, 4'b1000);
        checkOutput("mid_rst_data", data_out, 7'h3F);
        checkOutput("mid_rst_ack", load_ack, 1'b0);
        #1 reset = 1'b0;
        waitT(24);
        checkOutput("mid_rst_no_ack", load_ack, 1'b0);
        checkOutput("mid_rst_frame", frame_start, 1'b1);
        checkOutput("mid_rst_active", data_out, 7'h3F);
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-select 7-segment display, extending the 2-digit multiplexed display to four digits under timed sequencing. It generates a prescaled scan tick and steps through the digits with a programmable dwell and an inter-digit blanking gap (anti-ghosting). It double-buffers displayed data through a req/ack load handshake that applies only at frame boundaries (tear-free), and applies a digit-enable mask and leading-zero suppression.

Parameters:
DIV, 50000, clock cycles per scan tick (>=1)
DWELL, 4, ticks each digit is driven (>=1)
GAP, 1, blank ticks between digits (>=0; 0 = no gap state)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load_req  in  1  request to load new display value (level, held until load_ack)
load_data  in  16  four BCD/hex nibbles; [3:0] = digit0 (LSD), [15:12] = digit3
load_ack  out  1  one-cycle pulse when load_data becomes the active value
lz_en  in  1  leading-zero suppression enable
dig_en  in  4  per-digit enable; bit i = digit i
com  out  4  digit select, active-high; com[3-i] drives digit i (com[3] = LSD)
data_out  out  7  segment pattern of the currently scanned digit; bit0 = segment a
digit_idx  out  2  index of the digit currently scheduled
frame_start  out  1  one-cycle pulse on entering SHOW for digit 0

Behaviour:
- Reset (sync, dominant over all inputs): prescaler=0, dwell counter=0, state=SHOW, digit_idx=0, active=16'h0000, pending buffer=0, pending flag=0, load_ack=0, frame_start=0.
- Immediately after reset: com=4'b1000 and data_out=decode(0).
- Prescaler counts 0..DIV-1; tick asserts for one cycle when count==DIV-1, then wraps to 0. It runs free and is never stalled.
- FSM states:
  - SHOW: after DWELL ticks, go to GAP if GAP>0; otherwise go to SHOW with idx+1.
  - GAP: after GAP ticks, go to SHOW with idx+1 (mod 4). Wrap 3->0 is the frame boundary.
- Frame period is 4*(DWELL+GAP)*DIV cycles, independent of masking and suppression.
- com:
  - GAP: 4'b0000.
  - SHOW: one-hot com[3-idx]=1, unless dig_en[idx]=0 or the digit is suppressed; then 4'b0000.
- Leading-zero suppression (lz_en=1): digit i in 1..3 is suppressed iff active nibble i and all higher nibbles are 0. Digit 0 is never suppressed.
- data_out = decode(active[4*idx+:4]), combinational from registered state. Its value while com=0 is don't-care to the display but still deterministic.
- dig_en and lz_en are used combinationally; a change affects com in the same cycle.
- Load handshake:
  - Capture: in a cycle with load_req=1, pending=0 and load_ack=0, capture load_data into the pending buffer and set pending=1.
  - While pending=1, further load_data is ignored.
  - Apply: on the frame-boundary edge (entering SHOW idx 0) with pending=1, set active<=pending buffer, pending<=0, load_ack=1 for exactly one cycle, coincident with frame_start.
  - Requester drops load_req the cycle after load_ack. No capture occurs in the load_ack cycle, which prevents double capture.
  - A request arriving on the boundary edge itself is captured and applied at the next frame; there is no same-edge bypass.
- Reset mid-frame: pending data is discarded and no load_ack is issued.
- frame_start pulses on every frame boundary, including when no load occurs. It does not pulse out of reset.

Decomposition:
- Shared package: N_DIG=4, state encoding S_SHOW/S_GAP, com one-hot constant for each index.
- Sub-module tick_gen(clock, reset, tick), parameterised by DIV.
- Segment decode reuses the existing seg_7 decoder (one instance on the muxed nibble).
- FSM, counters and load buffer stay in seg_scan_ctrl.

Test Plan:
- Params DIV=2, DWELL=2, GAP=1, dig_en=1111, lz_en=0. Reset, then release -> com sequence 1000(4 cyc), 0000(2), 0100(4), 0000(2), 0010(4), 0000(2), 0001(4), 0000(2). frame_start pulses every 24 cycles. data_out=decode(0) throughout.
- load_req with load_data=16'h0042 mid-frame -> load_ack single pulse coincident with next frame_start. Digit slots then show 2,4,0,0. The value is unchanged before the boundary.
- load_req held one cycle past load_ack with new data 16'h1234 -> second capture only after load_ack deasserts. 1234 appears at the following frame boundary, not earlier.
- lz_en=1, active=16'h0042 -> com stays 0000 in digit2/3 slots. active=16'h0000 -> only the digit0 slot shows com=1000. active=16'h0400 -> digits 0,1,2 driven, digit3 dark.
- dig_en=4'b1110 -> digit0 slot is com=0000 while frame timing is unchanged (24 cycles). GAP=0 build -> no blank slots, frame=16 cycles.
- Reset asserted while pending=1 (load captured, boundary not reached) -> after reset active=0, no load_ack ever, com=1000.
